// File: rtl/dcache_coherent_responder.sv
`default_nettype none
// ============================================================================
// Module : dcache_coherent_responder
// Direct-mapped MSI L1 data cache controller with coherency snoop responder.
// Rev    : 1.0
// ============================================================================
module dcache_coherent_responder #(
    parameter int SETS = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        ccwrite,
    input  logic        dwait,
    input  logic [31:0] dload,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 32 - IDXW - 3;
    localparam logic [1:0] c_ST_I = 2'd0;
    localparam logic [1:0] c_ST_S = 2'd1;
    localparam logic [1:0] c_ST_M = 2'd2;

    typedef enum logic [2:0] {IDLE, WB0, WB1, LD0, LD1, SNP0, SNP1} state_t;
    state_t r_fsm;

    logic [1:0]      r_st  [SETS];
    logic [TAGW-1:0] r_tag [SETS];
    logic [31:0]     r_d0  [SETS];
    logic [31:0]     r_d1  [SETS];
    logic [31:0]     r_fill0;
    logic            r_snp_inv;
    logic [IDXW-1:0] r_snp_idx;

    logic [IDXW-1:0] w_idx, w_s_idx;
    logic [TAGW-1:0] w_tag, w_s_tag;
    logic            w_wsel, w_match, w_s_match, w_cpu_hit;
    logic            w_snp_entry, w_snp_hit_m, w_commit, w_store_wr;
    logic [31:0]     w_word;
    logic            w_unused;

    assign w_idx       = dmemaddr[IDXW+2:3];
    assign w_tag       = dmemaddr[31:IDXW+3];
    assign w_wsel      = dmemaddr[2];
    assign w_s_idx     = ccsnoopaddr[IDXW+2:3];
    assign w_s_tag     = ccsnoopaddr[31:IDXW+3];
    assign w_unused    = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};

    assign w_match     = (r_st[w_idx] != c_ST_I) && (r_tag[w_idx] == w_tag);
    assign w_s_match   = (r_st[w_s_idx] != c_ST_I) && (r_tag[w_s_idx] == w_s_tag);
    assign w_word      = w_wsel ? r_d1[w_idx] : r_d0[w_idx];
    assign w_cpu_hit   = (dmemREN && w_match) ||
                         (dmemWEN && w_match && (r_st[w_idx] == c_ST_M));
    // Snoops pre-empt everything except an already running snoop supply.
    assign w_snp_entry = ccwait && (r_fsm != SNP0) && (r_fsm != SNP1);
    assign w_snp_hit_m = w_s_match && (r_st[w_s_idx] == c_ST_M);
    assign w_commit    = nRST && !w_snp_entry && (r_fsm == LD1) && !dwait;
    assign w_store_wr  = nRST && !w_snp_entry && (r_fsm == IDLE) && dmemWEN && w_cpu_hit;

    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ccwrite  = 1'b0;
        if (w_snp_entry) begin
            if (w_snp_hit_m) begin
                dWEN   = 1'b1;
                daddr  = {ccsnoopaddr[31:3], 3'b000};
                dstore = r_d0[w_s_idx];
            end
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_cpu_hit) begin
                        dhit     = 1'b1;
                        dmemload = w_word;
                    end
                end
                WB0, WB1: begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[w_idx], w_idx, (r_fsm == WB1), 2'b00};
                    dstore = (r_fsm == WB1) ? r_d1[w_idx] : r_d0[w_idx];
                end
                LD0, LD1: begin
                    dREN    = 1'b1;
                    daddr   = {w_tag, w_idx, (r_fsm == LD1), 2'b00};
                    ccwrite = dmemWEN;
                end
                SNP0, SNP1: begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[r_snp_idx], r_snp_idx, (r_fsm == SNP1), 2'b00};
                    dstore = (r_fsm == SNP1) ? r_d1[r_snp_idx] : r_d0[r_snp_idx];
                end
                default: ;
            endcase
        end
        // Outputs clear immediately on reset, not at the next edge.
        if (!nRST) begin
            dhit     = 1'b0;
            dmemload = '0;
            dREN     = 1'b0;
            dWEN     = 1'b0;
            daddr    = '0;
            dstore   = '0;
            ccwrite  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_fsm     <= IDLE;
            r_fill0   <= '0;
            r_snp_inv <= 1'b0;
            r_snp_idx <= '0;
            for (int i = 0; i < SETS; i++) r_st[i] <= c_ST_I;
        end else if (w_snp_entry) begin
            r_fill0   <= '0;
            r_snp_inv <= ccinv;
            r_snp_idx <= w_s_idx;
            if (w_snp_hit_m) begin
                r_fsm <= SNP0;
            end else begin
                r_fsm <= IDLE;
                if (ccinv && w_s_match && (r_st[w_s_idx] == c_ST_S))
                    r_st[w_s_idx] <= c_ST_I;
            end
        end else begin
            case (r_fsm)
                IDLE: begin
                    if ((dmemREN || dmemWEN) && !w_cpu_hit) begin
                        if (!w_match && (r_st[w_idx] == c_ST_M)) r_fsm <= WB0;
                        else                                      r_fsm <= LD0;
                    end
                end
                WB0:  if (!dwait) r_fsm <= WB1;
                WB1: begin
                    if (!dwait) begin
                        r_st[w_idx] <= c_ST_I;
                        r_fsm       <= LD0;
                    end
                end
                LD0: begin
                    if (!dwait) begin
                        r_fill0 <= dload;
                        r_fsm   <= LD1;
                    end
                end
                LD1: begin
                    if (!dwait) begin
                        r_st[w_idx] <= dmemWEN ? c_ST_M : c_ST_S;
                        r_fsm       <= IDLE;
                    end
                end
                SNP0: if (!dwait) r_fsm <= SNP1;
                SNP1: begin
                    if (!dwait) begin
                        r_st[r_snp_idx] <= r_snp_inv ? c_ST_I : c_ST_S;
                        r_fsm           <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity lives in r_st.
    always_ff @(posedge CLK) begin
        if (w_commit) begin
            r_tag[w_idx] <= w_tag;
            r_d0[w_idx]  <= r_fill0;
            r_d1[w_idx]  <= dload;
        end
        if (w_store_wr) begin
            if (w_wsel) r_d1[w_idx] <= dmemstore;
            else        r_d0[w_idx] <= dmemstore;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_coherent_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_coherent_responder
// Directed bench with a transaction-level cache model checked every cycle.
// Rev    : 1.0
// ============================================================================
module tb_dcache_coherent_responder;
    localparam int SETS = 8;
    localparam int OP_NONE = 0, OP_WB = 1, OP_FILL = 2, OP_SUP = 3;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, dREN, dWEN, ccwrite;
    logic [31:0] dmemload, daddr, dstore, dload;
    logic        dwait = 1'b0, ccwait = 1'b0, ccinv = 1'b0;
    logic [31:0] ccsnoopaddr = '0;

    int n_checks = 0;
    int n_err    = 0;

    dcache_coherent_responder #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
    );

    always #5 CLK = ~CLK;

    // Backing memory for the bus side (word addresses below 0x100).
    logic [31:0] mem [64];
    assign dload = mem[daddr[7:2]];
    always @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem[16] <= 32'h1111_1111;
            mem[17] <= 32'h2222_2222;
            mem[32] <= 32'h3333_3333;
            mem[33] <= 32'h4444_4444;
        end else if (dWEN && !dwait) begin
            mem[daddr[7:2]] <= dstore;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [1:0]  mst  [SETS] = '{default: 2'd0};
    logic [25:0] mtag [SETS] = '{default: 26'd0};
    logic [31:0] md0  [SETS] = '{default: 32'd0};
    logic [31:0] md1  [SETS] = '{default: 32'd0};
    int          op = OP_NONE, wrd = 0, sidx = 0;
    logic        sinv = 1'b0;
    logic [31:0] mbuf = '0;

    function automatic bit m_hit(input logic [31:0] a);
        return (mst[a[5:3]] != 2'd0) && (mtag[a[5:3]] == a[31:6]);
    endfunction

    function automatic bit m_cpu_hit();
        return (dmemREN && m_hit(dmemaddr)) ||
               (dmemWEN && m_hit(dmemaddr) && mst[dmemaddr[5:3]] == 2'd2);
    endfunction

    function automatic logic [31:0] line_addr(input logic [25:0] t, input int idx, input int w);
        return (32'(t) << 6) | (32'(idx) << 3) | (32'(w) << 2);
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) mst[i] <= 2'd0;
            op  <= OP_NONE;
            wrd <= 0;
        end else if (ccwait && op != OP_SUP) begin
            op  <= OP_NONE;
            wrd <= 0;
            if (m_hit(ccsnoopaddr) && mst[ccsnoopaddr[5:3]] == 2'd2) begin
                op   <= OP_SUP;
                sidx <= int'(ccsnoopaddr[5:3]);
                sinv <= ccinv;
            end else if (ccinv && m_hit(ccsnoopaddr) && mst[ccsnoopaddr[5:3]] == 2'd1) begin
                mst[ccsnoopaddr[5:3]] <= 2'd0;
            end
        end else begin
            case (op)
                OP_NONE: begin
                    if (m_cpu_hit()) begin
                        if (dmemWEN && dmemaddr[2])  md1[dmemaddr[5:3]] <= dmemstore;
                        if (dmemWEN && !dmemaddr[2]) md0[dmemaddr[5:3]] <= dmemstore;
                    end else if (dmemREN || dmemWEN) begin
                        op  <= (!m_hit(dmemaddr) && mst[dmemaddr[5:3]] == 2'd2) ? OP_WB : OP_FILL;
                        wrd <= 0;
                    end
                end
                OP_WB: if (!dwait) begin
                    if (wrd == 1) begin
                        mst[dmemaddr[5:3]] <= 2'd0;
                        op  <= OP_FILL;
                        wrd <= 0;
                    end else wrd <= 1;
                end
                OP_FILL: if (!dwait) begin
                    if (wrd == 0) begin
                        mbuf <= dload;
                        wrd  <= 1;
                    end else begin
                        mtag[dmemaddr[5:3]] <= dmemaddr[31:6];
                        md0[dmemaddr[5:3]]  <= mbuf;
                        md1[dmemaddr[5:3]]  <= dload;
                        mst[dmemaddr[5:3]]  <= dmemWEN ? 2'd2 : 2'd1;
                        op  <= OP_NONE;
                        wrd <= 0;
                    end
                end
                default: if (!dwait) begin
                    if (wrd == 1) begin
                        mst[sidx] <= sinv ? 2'd0 : 2'd1;
                        op  <= OP_NONE;
                        wrd <= 0;
                    end else wrd <= 1;
                end
            endcase
        end
    end

    logic        e_dhit, e_dren, e_dwen, e_ccw;
    logic [31:0] e_load, e_daddr, e_dstore;
    always @(negedge CLK) begin
        #3;
        {e_dhit, e_dren, e_dwen, e_ccw} = 4'b0;
        {e_load, e_daddr, e_dstore} = '0;
        if (nRST) begin
            if (ccwait && op != OP_SUP) begin
                if (m_hit(ccsnoopaddr) && mst[ccsnoopaddr[5:3]] == 2'd2) begin
                    e_dwen   = 1'b1;
                    e_daddr  = ccsnoopaddr & ~32'h7;
                    e_dstore = md0[ccsnoopaddr[5:3]];
                end
            end else if (op == OP_NONE) begin
                e_dhit = m_cpu_hit();
                e_load = dmemaddr[2] ? md1[dmemaddr[5:3]] : md0[dmemaddr[5:3]];
            end else if (op == OP_WB) begin
                e_dwen   = 1'b1;
                e_daddr  = line_addr(mtag[dmemaddr[5:3]], int'(dmemaddr[5:3]), wrd);
                e_dstore = (wrd == 1) ? md1[dmemaddr[5:3]] : md0[dmemaddr[5:3]];
            end else if (op == OP_FILL) begin
                e_dren  = 1'b1;
                e_daddr = (dmemaddr & ~32'h7) | (32'(wrd) << 2);
                e_ccw   = dmemWEN;
            end else begin
                e_dwen   = 1'b1;
                e_daddr  = line_addr(mtag[sidx], sidx, wrd);
                e_dstore = (wrd == 1) ? md1[sidx] : md0[sidx];
            end
        end
        chk("m_dhit", 32'(dhit), 32'(e_dhit));
        chk("m_dREN", 32'(dREN), 32'(e_dren));
        chk("m_dWEN", 32'(dWEN), 32'(e_dwen));
        chk("m_ccwrite", 32'(ccwrite), 32'(e_ccw));
        if (e_dhit && dmemREN) chk("m_dmemload", dmemload, e_load);
        if (e_dren || e_dwen)  chk("m_daddr", daddr, e_daddr);
        if (e_dwen)            chk("m_dstore", dstore, e_dstore);
        if (!nRST) chk("m_reset_out", {dmemload | daddr | dstore}, 32'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge CLK);
        #2;
    endtask

    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        dmemREN = r; dmemWEN = w; dmemaddr = a; dmemstore = d;
    endtask

    task automatic finish_req();
        @(posedge CLK);
        #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
        cyc();
    endtask

    task automatic wait_bus(input string nm);
        int n = 0;
        cyc();
        while (!(dREN || dWEN) && n < 20) begin cyc(); n++; end
        chk({nm, "_bus_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_hit(input string nm);
        int n = 0;
        cyc();
        while (!dhit && n < 20) begin cyc(); n++; end
        chk({nm, "_hit_timeout"}, 32'(n < 20), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        cyc(); cyc();
        chk("rst_outs", {29'd0, dhit, dREN, dWEN} | {31'd0, ccwrite}, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        nRST = 1'b1;
        cyc();

        // Load miss 0x40
        req(1, 0, 32'h40, 0);
        wait_bus("ld40");
        chk("ld40_w0_addr", daddr, 32'h40);
        chk("ld40_w0_ren", {dREN, ccwrite}, 32'b10);
        cyc();
        chk("ld40_w1_addr", daddr, 32'h44);
        cyc();
        chk("ld40_hit", 32'(dhit), 32'd1);
        chk("ld40_data", dmemload, 32'h1111_1111);
        finish_req();

        // Store to S line: upgrade
        req(0, 1, 32'h44, 32'hDEAD_BEEF);
        wait_bus("st44");
        chk("st44_w0", {daddr[7:0], 6'd0, dREN, ccwrite}, {8'h40, 6'd0, 2'b11});
        cyc();
        chk("st44_w1", {daddr[7:0], 6'd0, dREN, ccwrite}, {8'h44, 6'd0, 2'b11});
        wait_hit("st44");
        finish_req();
        req(1, 0, 32'h44, 0);
        #1;
        chk("ld44_hit", 32'(dhit), 32'd1);
        chk("ld44_data", dmemload, 32'hDEAD_BEEF);
        chk("ld44_nobus", {30'd0, dREN, dWEN}, 32'd0);
        finish_req();

        // Conflict miss with dirty victim
        req(1, 0, 32'h80, 0);
        wait_bus("ld80");
        chk("wb0", {daddr, 31'd0, dWEN}, {32'h40, 32'd1});
        chk("wb0_data", dstore, 32'h1111_1111);
        cyc();
        chk("wb1", daddr, 32'h44);
        chk("wb1_data", dstore, 32'hDEAD_BEEF);
        cyc();
        chk("ld80_w0", {daddr, 31'd0, dREN}, {32'h80, 32'd1});
        cyc();
        chk("ld80_w1", daddr, 32'h84);
        cyc();
        chk("ld80_data", {dmemload[31:1], dhit}, {31'h1999_9999, 1'b1});
        finish_req();

        // Make 0x40 dirty, then snoop without invalidate
        req(0, 1, 32'h44, 32'hCAFE_F00D);
        wait_hit("st44b");
        finish_req();
        ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b0;
        #1;
        chk("snp_entry", {daddr, 31'd0, dWEN}, {32'h40, 32'd1});
        chk("snp_entry_data", dstore, 32'h1111_1111);
        cyc();
        ccwait = 1'b0;
        chk("snp0", daddr, 32'h40);
        cyc();
        chk("snp1", daddr, 32'h44);
        chk("snp1_data", dstore, 32'hCAFE_F00D);
        cyc();
        req(1, 0, 32'h40, 0);
        #1;
        chk("post_snp_hit", {dhit, dREN, dWEN}, 32'b100);
        chk("post_snp_data", dmemload, 32'h1111_1111);
        finish_req();

        // Invalidating snoop on S line
        ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b1;
        #1;
        chk("inv_nowen", 32'(dWEN), 32'd0);
        cyc();
        ccwait = 1'b0; ccinv = 1'b0;
        req(1, 0, 32'h40, 0);
        #1;
        chk("inv_miss", 32'(dhit), 32'd0);
        wait_bus("inv_refill");
        chk("inv_refill", {daddr, 31'd0, dREN}, {32'h40, 32'd1});
        wait_hit("inv_refill");
        chk("inv_refill_data", dmemload, 32'h1111_1111);
        finish_req();

        // Snoop arriving while a fill stalls
        dwait = 1'b1;
        req(1, 0, 32'h80, 0);
        wait_bus("stall");
        cyc();
        ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b0;
        #1;
        chk("stall_snp_dren", {30'd0, dREN, dWEN}, 32'd0);
        cyc();
        ccwait = 1'b0; dwait = 1'b0;
        wait_bus("restart");
        chk("restart_w0", {daddr, 31'd0, dREN}, {32'h80, 32'd1});
        cyc();
        chk("restart_w1", daddr, 32'h84);
        cyc();
        chk("restart_data", {dmemload, 31'd0, dhit}, {32'h3333_3333, 32'd1});
        finish_req();

        // Reset during write-back
        req(1, 0, 32'h08, 0);
        wait_hit("ld08");
        chk("ld08_data", dmemload, 32'hA000_0002);
        finish_req();
        req(0, 1, 32'h84, 32'h1234_5678);
        wait_hit("st84");
        finish_req();
        req(1, 0, 32'h00, 0);
        wait_bus("ld00");
        chk("rwb0", {daddr, dstore}, {32'h80, 32'h3333_3333});
        cyc();
        chk("rwb1", {daddr, dstore}, {32'h84, 32'h1234_5678});
        nRST = 1'b0;
        #1;
        chk("mid_rst_outs", {28'd0, dhit, dREN, dWEN, ccwrite}, 32'd0);
        chk("mid_rst_bus", daddr | dstore | dmemload, 32'd0);
        cyc();
        nRST = 1'b1;
        wait_bus("ld00_after");
        chk("ld00_after", {daddr, 30'd0, dREN, dWEN}, {32'h00, 32'b10});
        wait_hit("ld00_after");
        chk("ld00_data", dmemload, 32'hA000_0000);
        finish_req();
        req(1, 0, 32'h08, 0);
        #1;
        chk("ld08_after_rst", 32'(dhit), 32'd0);
        wait_bus("ld08_after");
        chk("ld08_after_addr", {daddr, 31'd0, dREN}, {32'h08, 32'd1});
        wait_hit("ld08_after");
        finish_req();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dcache_coherent_responder.md
Name: dcache_coherent_responder

Overview:
- Per-core L1 data cache controller; the cache-side end of the coherency bus that the coherency controller drives.
- Serves CPU loads and stores from a direct-mapped MSI cache.
- Issues block fills, write-backs and upgrades on the bus (dREN/dWEN/ccwrite).
- Answers controller snoops (ccwait/ccinv/ccsnoopaddr): supplies dirty data via dWEN (cache-to-cache) and downgrades or invalidates lines.

Parameters:
- SETS, 8: number of direct-mapped sets; power of two; IDXW = log2(SETS).
- Block is fixed at 2 words. Address fields: [1:0] byte offset, [2] word select, [IDXW+2:3] index, [31:IDXW+3] tag.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- dmemREN  in  1  CPU load request
- dmemWEN  in  1  CPU store request; never asserted together with dmemREN
- dmemaddr  in  32  CPU word address
- dmemstore  in  32  CPU store data
- dhit  out  1  request completes this cycle
- dmemload  out  32  load data, valid when dhit=1
- dREN  out  1  bus block-fill read
- dWEN  out  1  bus write (write-back or snoop supply)
- daddr  out  32  bus word address
- dstore  out  32  bus write data
- ccwrite  out  1  current fill is for ownership; peers invalidate
- dwait  in  1  bus word not yet accepted/returned
- dload  in  32  bus read data
- ccwait  in  1  snoop request to this cache
- ccinv  in  1  snoop invalidates
- ccsnoopaddr  in  32  snooped address

Behaviour:
- Reset (nRST asynchronous, active-low; clock CLK):
  - all lines state I; FSM in IDLE; fill buffer cleared.
  - all outputs 0: dhit, dmemload, dREN, dWEN, daddr, dstore, ccwrite.
- Line state: 2-bit MSI, tag, two data words.
- FSM states: IDLE, WB0, WB1, LD0, LD1, SNP0, SNP1.
- IDLE, lookup on dmemaddr:
  - Load hit (S or M): combinational dhit=1, dmemload = word. Zero-cycle latency.
  - Store hit in M: dhit=1; word written at the clock edge.
  - Store hit in S is a miss needing an upgrade: go to LD0 with ccwrite=1.
  - Miss with victim in M: go to WB0. Other misses: go to LD0.
- WB0/WB1 (write-back):
  - dWEN=1, daddr = {victim tag, idx, word, 00}, dstore = victim word.
  - Advance on dwait=0; WB1 done -> victim state I -> LD0.
- LD0/LD1 (fill):
  - dREN=1, daddr = {req tag, idx, word, 00}; ccwrite=1 iff the pending request is a store.
  - On dwait=0, latch dload into the fill buffer.
  - LD1 done: commit tag and both words; state M if store, else S; go to IDLE.
  - The request hits on the following cycle.
- dhit is only ever 1 in IDLE.
- Snoop entry (ccwait=1 in any non-SNP state): snoop has priority.
  - The in-progress CPU bus transaction is abandoned and dREN is dropped that cycle.
  - The uncommitted fill buffer is discarded.
  - A completed WB0 word may be rewritten later; this is harmless.
- Snoop lookup is combinational on ccsnoopaddr (same index/tag split).
  - Hit in M: the same cycle as ccwait rises, drive dWEN=1, daddr = {tag, idx, 0, 00}, dstore = word0. Next state is SNP0.
  - Hit in S or I, or a miss: no dWEN. At the edge, if ccinv=1 and the line is S, it becomes I. Next state is IDLE.
- SNP0: hold dWEN/daddr/dstore for word0 until dwait=0, then SNP1.
- SNP1: dWEN=1, word1 at {tag, idx, 1, 00}; on dwait=0:
  - line becomes I if ccinv was 1 at entry (latched), else S;
  - go to IDLE.
- After any snoop, the FSM returns to IDLE and restarts the CPU request with a fresh lookup.
- ccwait is ignored while in SNP0/SNP1.
- Snoop to the line being filled (LD pending): the snoop sees the old line state. The fill restarts after the snoop.
- Mid-operation reset: immediate return to reset state. Dirty data is lost (acceptable).

Test Plan:
- Reset, then load 0x40 (miss, SETS=8).
  - Bus must show dREN=1 daddr=0x40, then daddr=0x44, with ccwrite=0.
  - dload 0x11111111/0x22222222.
  - Next cycle dhit=1, dmemload=0x11111111; line S.
- Store 0x44 ← 0xDEADBEEF to the S line.
  - Refill with ccwrite=1 at 0x40/0x44.
  - Then dhit=1; line M; a later load of 0x44 returns 0xDEADBEEF with no bus activity.
- With 0x40 in M, load 0x80 (same index, new tag).
  - dWEN at 0x40 (0x11111111), then 0x44 (0xDEADBEEF).
  - Then dREN at 0x80/0x84; line S tag 0x80.
- With 0x40 in M, pulse ccwait with ccsnoopaddr=0x40, ccinv=0.
  - Same cycle: dWEN=1, daddr=0x40, dstore=0x11111111.
  - After two dwait-low words: line S; dhit on a load of 0x40 with no bus activity.
- Snoop with ccinv=1 on an S line.
  - dWEN stays 0; line I; next load of that address misses (dREN).
- Load miss in LD0 with dwait=1, then ccwait arrives.
  - dREN=0 that cycle; snoop is serviced.
  - Fill restarts at word 0 and completes with correct data.
- Assert nRST low during WB1.
  - All outputs 0 immediately; all lines I after release.
